// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the five-stage MIPS pipeline.
// Holds the multiply/divide operation encodings, default latencies,
// the md_unit FSM state type and the reset PC used by the pipeline registers.
package mips_pkg;

  // Multiply/divide operation encodings carried in the ID/EX register
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Default busy latencies of the multiply/divide unit
  localparam int MD_MULT_CYCLES_DEFAULT = 5;
  localparam int MD_DIV_CYCLES_DEFAULT  = 10;

  // Reset PC shared by the pipeline registers (boot ROM vector)
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  // md_unit sequencing states
  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // True for the four operations that occupy the unit for several cycles
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // True for the two divide operations, which use the longer latency
  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational result generator for mult/multu/div/divu.
// Produces the values that HI/LO will take once the busy time has elapsed.
// A zero divisor returns the current HI/LO so the registers are left untouched.
module md_calc
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] p_hi,
  output logic [31:0] p_lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Products from sign/zero-extended operands; the low 64 bits of the
  // sign-extended product are the exact two's complement signed product.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // Division shares one unsigned divider: signed ops divide the magnitudes and
  // fix up signs afterwards, which also yields 0x80000000 / -1 = 0x80000000
  // without overflow. The divisor is forced nonzero so the divider never sees 0.
  always_comb begin
    abs_a = a[31] ? (~a + 32'd1) : a;
    abs_b = b[31] ? (~b + 32'd1) : b;
    div_a = (op == MD_DIV) ? abs_a : a;
    div_b = (op == MD_DIV) ? abs_b : b;
    if (div_b == 32'd0) begin
      div_b = 32'd1;
    end
    q_u = div_a / div_b;
    r_u = div_a % div_b;
    q_s = (a[31] ^ b[31]) ? (~q_u + 32'd1) : q_u;
    r_s = a[31] ? (~r_u + 32'd1) : r_u;
  end

  // Select the pending HI/LO pair for the requested operation
  always_comb begin
    p_hi = hi;
    p_lo = lo;
    case (op)
      MD_MULT: begin
        p_hi = prod_s[63:32];
        p_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        p_hi = prod_u[63:32];
        p_lo = prod_u[31:0];
      end
      MD_DIV: begin
        if (b != 32'd0) begin
          p_hi = r_s;
          p_lo = q_s;
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          p_hi = r_u;
          p_lo = q_u;
        end
      end
      default: begin
        p_hi = hi;
        p_lo = lo;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning HI/LO.
// A multi-cycle operation computes its result up front into p_hi/p_lo, then
// counts down its latency and commits to HI/LO on the final busy edge.
// start (combinational) and busy (registered) drive the decode-stage stall.
module md_unit
  import mips_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rd
);

  // Counter must hold the larger of the two latencies
  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      p_hi;
  logic [31:0]      p_lo;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;

  md_calc u_calc (
    .op   (md_op),
    .a    (A),
    .b    (B),
    .hi   (HI),
    .lo   (LO),
    .p_hi (calc_hi),
    .p_lo (calc_lo)
  );

  // Accept a new operation only while idle so the stall asserts in the same cycle
  always_comb begin
    start = (state == MD_IDLE) && is_md_start(md_op);
  end

  // MFHI/MFLO read the architectural registers, never the pending result
  always_comb begin
    case (md_op)
      MD_MFHI: md_rd = HI;
      MD_MFLO: md_rd = LO;
      default: md_rd = 32'd0;
    endcase
  end

  // Sequencer: latch result and latency on start, count down, commit on the last busy edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            p_hi  <= calc_hi;
            p_lo  <= calc_lo;
            cnt   <= is_md_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            busy  <= 1'b1;
            state <= MD_BUSY;
          end else if (md_op == MD_MTHI) begin
            HI <= A;
          end else if (md_op == MD_MTLO) begin
            LO <= A;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            HI    <= p_hi;
            LO    <= p_lo;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit with hand-computed results.
module tb_md_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_rd;

  int vectors;
  int miscompares;

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .md_rd (md_rd)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the E-stage operation and operands
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    A     = a;
    B     = b;
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one multi-cycle op, verify start/busy timing, then the committed HI/LO
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    applyStimulus(op, a, b);
    #1;
    checkOutput({tag, " start"}, 32'(start), 32'd1);
    waitCycle();
    checkOutput({tag, " start while busy"}, 32'(start), 32'd0);
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      waitCycle();
    end
    checkOutput({tag, " busy fall"}, 32'(busy), 32'd0);
    checkOutput({tag, " HI"}, HI, exp_hi);
    checkOutput({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    #3;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    checkOutput("reset start", 32'(start), 32'd0);
    waitCycle();
    waitCycle();
    reset = 1'b1;
    waitCycle();

    runOp("mult -2*3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("div -7/2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu 7/2", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    runOp("div min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
    waitCycle();
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    checkOutput("mthi HI", HI, 32'h1234_5678);
    checkOutput("mthi LO kept", LO, 32'h8000_0000);
    runOp("div by zero", MD_DIV, 32'd5, 32'd0, 10, 32'h1234_5678, 32'h8000_0000);

    applyStimulus(MD_MTLO, 32'h0BAD_F00D, 32'd0);
    waitCycle();
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    checkOutput("mtlo LO", LO, 32'h0BAD_F00D);

    // Ops presented while busy must be ignored
    applyStimulus(MD_MULT, 32'd6, 32'd7);
    waitCycle();
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    checkOutput("ign busy1", 32'(busy), 32'd1);
    waitCycle();
    applyStimulus(MD_DIVU, 32'd100, 32'd3);
    #1;
    checkOutput("ign busy2", 32'(busy), 32'd1);
    checkOutput("ign start", 32'(start), 32'd0);
    waitCycle();
    applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    checkOutput("ign busy3", 32'(busy), 32'd1);
    waitCycle();
    checkOutput("ign busy4", 32'(busy), 32'd1);
    checkOutput("ign LO held", LO, 32'h0BAD_F00D);
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    waitCycle();
    checkOutput("ign busy5", 32'(busy), 32'd1);
    waitCycle();
    checkOutput("ign busy fall", 32'(busy), 32'd0);
    checkOutput("ign HI", HI, 32'd0);
    checkOutput("ign LO", LO, 32'd42);

    // Asynchronous reset in busy cycle 6 of a divide
    applyStimulus(MD_DIV, 32'd100, 32'd7);
    waitCycle();
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    for (int i = 1; i < 6; i++) begin
      waitCycle();
    end
    checkOutput("abort busy before", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort HI", HI, 32'd0);
    checkOutput("abort LO", LO, 32'd0);
    #2;
    reset = 1'b1;
    waitCycle();
    runOp("mult 4*5", MD_MULT, 32'd4, 32'd5, 5, 32'd0, 32'd20);

    // Move-from paths and unencoded op
    applyStimulus(MD_MTHI, 32'hA5A5_0001, 32'd0);
    waitCycle();
    applyStimulus(MD_MFHI, 32'd0, 32'd0);
    #1;
    checkOutput("mfhi", md_rd, 32'hA5A5_0001);
    applyStimulus(MD_MFLO, 32'd0, 32'd0);
    #1;
    checkOutput("mflo", md_rd, 32'd20);
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    #1;
    checkOutput("md_rd none", md_rd, 32'd0);
    applyStimulus(4'hF, 32'hFFFF_FFFF, 32'd1);
    #1;
    checkOutput("bad op start", 32'(start), 32'd0);
    waitCycle();
    checkOutput("bad op busy", 32'(busy), 32'd0);
    checkOutput("bad op HI", HI, 32'hA5A5_0001);
    checkOutput("bad op LO", LO, 32'd20);
    applyStimulus(MD_NONE, 32'd0, 32'd0);
    waitCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
